// File: rtl/sram_pkg.sv
// Shared types and default geometry for the SRAM bit-cell array controller.
package sram_pkg;
   localparam int SRAM_ROWS = 64;
   localparam int SRAM_COLS = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/sram_ctrl.sv
// Single-outstanding request/response front end for a bit-cell array; response sampled 2 edges after accept (1 for bad address), held until resp_ready.
// Define SRAM_CTRL_WMASK_EN to add the req_wmask per-bit write mask port; otherwise writes strobe every column.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ROWS = SRAM_ROWS,
   parameter int COLS = SRAM_COLS,
   localparam int AW = $clog2(ROWS)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [COLS-1:0] req_wdata,
`ifdef SRAM_CTRL_WMASK_EN
   input  logic [COLS-1:0] req_wmask,
`endif
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [COLS-1:0] resp_rdata,
   output logic            resp_err,
   output logic [AW-1:0]   arr_row_select,
   output logic [COLS-1:0] arr_col_write_enable,
   output logic [COLS-1:0] arr_col_data_in,
   input  logic [COLS-1:0] arr_col_data_out
);

   state_t          r_state;
   state_t          w_next;
   logic            w_req_hs;
   logic            w_addr_err;
   logic [AW-1:0]   r_row_sel;
   logic [COLS-1:0] r_data_in;
   logic [COLS-1:0] r_rdata;
   logic            r_err;
   logic [COLS-1:0] w_wr_mask;

   assign w_req_hs   = req_valid && req_ready;
   assign w_addr_err = (32'(req_addr) >= 32'(ROWS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_hs) begin
               if (w_addr_err) begin
                  w_next = ST_RESP;
               end else if (req_we) begin
                  w_next = ST_WRITE;
               end else begin
                  w_next = ST_READ;
               end
            end
         end
         ST_WRITE: w_next = ST_RESP;
         ST_READ:  w_next = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Strobe is decoded from state so an async reset kills it in the same instant.
   always_comb begin
      req_ready            = 1'b0;
      resp_valid           = 1'b0;
      arr_col_write_enable = '0;
      case (r_state)
         ST_IDLE:  req_ready            = !rst;
         ST_WRITE: arr_col_write_enable = w_wr_mask;
         ST_RESP:  resp_valid           = 1'b1;
         default:  ;
      endcase
   end

`ifdef SRAM_CTRL_WMASK_EN
   logic [COLS-1:0] r_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
      end else if (w_req_hs && req_we && !w_addr_err) begin
         r_mask <= req_wmask;
      end
   end

   assign w_wr_mask = r_mask;
`else
   assign w_wr_mask = '1;
`endif

   // Row/data registers double as the array drive, so they only move on a real access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_sel <= '0;
         r_data_in <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_req_hs) begin
            r_rdata <= '0;
            r_err   <= w_addr_err;
            if (!w_addr_err) begin
               r_row_sel <= req_addr;
               if (req_we) begin
                  r_data_in <= req_wdata;
               end
            end
         end
         if (r_state == ST_READ) begin
            r_rdata <= arr_col_data_out;
         end
      end
   end

   assign arr_row_select  = r_row_sel;
   assign arr_col_data_in = r_data_in;
   assign resp_rdata      = r_rdata;
   assign resp_err        = r_err;

endmodule
